hall_emulator: RTL
==================

# hall_emulator

Generates the 3-bit Hall-effect sensor code a BLDC motor would produce, at a programmable commutation rate and direction. It is the source end of the Hall interface: its `h` output drives the commutation decoder in place of the motor's sensors, for bench bring-up, closed-loop firmware testing, and open-loop startup. It also reports sector position, a per-step strobe, and a signed electrical-revolution count.

## Interface
Parameters:
- `PERIOD_W`, 16: width of the step-period input and the internal cycle counter.
- `REV_W`, 16: width of the electrical-revolution counter.

Ports:
- `clk`  in  1: the single clock; all logic is on its rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `en`  in  1: run enable; level-sensitive.
- `load`  in  1: one-cycle strobe that latches `period` and `dir`.
- `period`  in  PERIOD_W: clock cycles per Hall state. Value 0 means stopped.
- `dir`  in  1: direction. 0 = forward (sector +1), 1 = reverse (sector −1).
- `h`  out  3: emulated Hall code `{h1,h2,h3}`; registered.
- `sector`  out  3: current sector index, 0..5; registered.
- `step`  out  1: one-cycle pulse on the cycle in which `h` takes a new value.
- `rev`  out  REV_W: signed electrical revolutions, two's complement, wrapping.
- `running`  out  1: high while the FSM is in RUN.

## Operation
- Sector-to-code map (forward order, one bit changes per step):
  - 0 → 101
  - 1 → 100
  - 2 → 110
  - 3 → 010
  - 4 → 011
  - 5 → 001
- The emulator never emits 000 or 111, except under the fault option.
- Reset values:
  - `h` = 101, `sector` = 0, `step` = 0, `rev` = 0, `running` = 0.
  - Internal state: `period_q` = 0, `dir_q` = 0, counter = 0, FSM = IDLE.
- `load` (any state): `period_q` ← `period`, `dir_q` ← `dir`, counter ← 0. A load never produces a step on its own cycle.
- FSM states:
  - IDLE: `h` and `sector` hold; counter held at 0. Goes to RUN when `en` = 1 and `period_q` ≠ 0, using the registered value.
  - RUN: counter increments each cycle. When counter = `period_q` − 1:
    - counter ← 0;
    - `sector` advances mod 6 in direction `dir_q`;
    - `h` ← new code;
    - `step` = 1.
  - RUN → IDLE on the next edge when `en` = 0, or when `period_q` becomes 0 through a load. Counter clears; `h` holds.
- Revolution counter:
  - Forward wrap 5→0: `rev` += 1.
  - Reverse wrap 0→5: `rev` −= 1.
  - `rev` wraps modulo 2^REV_W with no saturation.
- A direction change through `load` takes effect at the next step; `sector` stays continuous, with no skipped or repeated code.
- `period_q` = 1: a step every cycle in RUN; `h` changes every clock.

## Timing
- All outputs are registered. `step`, `sector`, `h` and `rev` update on the same edge.
- Latency from RUN entry:
  - RUN entered at edge k.
  - First `h` change at edge k + `period_q`.
  - Each later change every `period_q` edges.
- `en` rising seen at edge n → `running` = 1 after edge n (if `period_q` ≠ 0).
- `en` falling → `running` = 0 on the next edge; no step on that edge, even if the counter is terminal.
- `load` coincident with terminal count: load wins. No step; counter ← 0; the next step is a full new period later.
- `rst_n` low mid-run: on the next edge all outputs return to reset values, regardless of `en` or `load`.

## Configuration
- Macro `HALL_EMU_FAULT_EN`, when defined:
  - Adds input `fault_mode` [1:0]:
    - 00 = normal;
    - 01 = force `h` to 000 (sensor disconnected);
    - 10 = force `h` to 111 (invalid);
    - 11 = freeze `h` at its current value while `sector` keeps advancing (stuck sensor).
  - While forced, `step` is suppressed; `sector`, `rev` and the counter keep running.
  - Releasing the force outputs the current sector's code on the next edge.
- Macro undefined: the port is absent, and `h` is always the mapped sector code.

## Test plan
- Reset then idle: `rst_n` = 0 for 2 cycles, then `en` = 0 → `h` = 101, `sector` = 0, `rev` = 0, `step` = 0, held for 50 cycles.
- Forward run: `load` with `period` = 4, `dir` = 0, then `en` = 1 → `h` sequence 100,110,010,011,001,101, one change every 4 cycles. `step` pulses six times; `rev` = 1 after the 6th step.
- Reverse across wrap: from `sector` 0, `rev` = 0, with `period` = 1, `dir` = 1 → next `h` = 001 (sector 5), `rev` = −1 (all ones); steps occur on consecutive cycles.
- Collision: `load` `period` = 8 on the exact terminal-count cycle of `period` = 3 → no step that cycle; next step 8 cycles later.
- Stop and reset mid-run:
  - `en` deasserted → `running` = 0 next edge; `h` holds.
  - `load` `period` = 0 while `en` = 1 → exits RUN.
  - `rst_n` low mid-run → all reset values.
- With `HALL_EMU_FAULT_EN`:
  - `fault_mode` = 01 → `h` = 000, no `step`, `sector` still advancing.
  - `fault_mode` = 11 → `h` frozen at its current value, no `step`, `sector` still advancing.
  - Release to 00 → `h` = code of current `sector` on the next edge.

Source files
------------

// File: rtl/hall_emulator.sv
// hall_emulator: programmable BLDC Hall-code source with sector, step and rev outputs.
// Optional macro HALL_EMU_FAULT_EN adds fault_mode to force or freeze the Hall code.
module hall_emulator #(
    parameter int PERIOD_W = 16,
    parameter int REV_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                load,
    input  logic [PERIOD_W-1:0] period,
    input  logic                dir,
`ifdef HALL_EMU_FAULT_EN
    input  logic [1:0]          fault_mode,
`endif
    output logic [2:0]          h,
    output logic [2:0]          sector,
    output logic                step,
    output logic [REV_W-1:0]    rev,
    output logic                running
);

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                dir_q, dir_d;
    logic [2:0]          sector_q, sector_d;
    logic [2:0]          h_q, h_d;
    logic                step_q, step_d;
    logic [REV_W-1:0]    rev_q, rev_d;
    logic                adv;

    function automatic logic [2:0] code_of(input logic [2:0] s);
        logic [2:0] c;
        unique case (s)
            3'd0:    c = 3'b101;
            3'd1:    c = 3'b100;
            3'd2:    c = 3'b110;
            3'd3:    c = 3'b010;
            3'd4:    c = 3'b011;
            3'd5:    c = 3'b001;
            default: c = 3'b101;
        endcase
        return c;
    endfunction

    // Next-state: FSM, step counter, load latch, sector/rev advance, Hall code
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        sector_d = sector_q;
        rev_d    = rev_q;
        adv      = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en && period_q != '0) state_d = RUN;
            end
            RUN: begin
                if (!en || period_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == period_q - PERIOD_W'(1)) begin
                    cnt_d = '0;
                    adv   = 1'b1;
                end else begin
                    cnt_d = cnt_q + PERIOD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A load restarts the period and suppresses any step on its own cycle
        if (load) begin
            period_d = period;
            dir_d    = dir;
            cnt_d    = '0;
            adv      = 1'b0;
        end

        if (adv) begin
            if (dir_q) begin
                if (sector_q == 3'd0) begin
                    sector_d = 3'd5;
                    rev_d    = rev_q - REV_W'(1);
                end else begin
                    sector_d = sector_q - 3'd1;
                end
            end else begin
                if (sector_q == 3'd5) begin
                    sector_d = 3'd0;
                    rev_d    = rev_q + REV_W'(1);
                end else begin
                    sector_d = sector_q + 3'd1;
                end
            end
        end

`ifdef HALL_EMU_FAULT_EN
        unique case (fault_mode)
            2'b01:   h_d = 3'b000;
            2'b10:   h_d = 3'b111;
            2'b11:   h_d = h_q;
            default: h_d = code_of(sector_d);
        endcase
        step_d = adv && (fault_mode == 2'b00);
`else
        h_d    = code_of(sector_d);
        step_d = adv;
`endif
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            period_q <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            sector_q <= 3'd0;
            h_q      <= 3'b101;
            step_q   <= 1'b0;
            rev_q    <= '0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            sector_q <= sector_d;
            h_q      <= h_d;
            step_q   <= step_d;
            rev_q    <= rev_d;
        end
    end

    assign h       = h_q;
    assign sector  = sector_q;
    assign step    = step_q;
    assign rev     = rev_q;
    assign running = (state_q == RUN);

endmodule
